// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and registered write/read error pulses.
// Optional occupancy output `level` is enabled by defining SYNC_FIFO_LEVEL_EN.
module sync_fifo #(
  parameter int width     = 8,
  parameter int depth     = 16,
  parameter int ptr_width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [width-1:0] wdata,
  output logic             full,
  output logic             werr,
  input  logic             ren,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             rerr
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  output logic [ptr_width:0] level
`endif
);

  // Handshake: a write is accepted on any edge with wen=1 and full=0, a read on
  // any edge with ren=1 and empty=0, both judged on pre-edge flags. A request
  // that is not accepted is dropped and raises werr/rerr for the next cycle.
  localparam logic [ptr_width:0] ptr_one = {{ptr_width{1'b0}}, 1'b1};

  logic [width-1:0]  mem_q [depth];
  logic [ptr_width:0] wptr_q, wptr_d;
  logic [ptr_width:0] rptr_q, rptr_d;
  logic [width-1:0]  rdata_q, rdata_d;
  logic              werr_q, werr_d;
  logic              rerr_q, rerr_d;
  logic              wr_accept, rd_accept;

  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[ptr_width] != rptr_q[ptr_width]) &&
                (wptr_q[ptr_width-1:0] == rptr_q[ptr_width-1:0]);
    wr_accept = wen && !full;
    rd_accept = ren && !empty;
    wptr_d    = wr_accept ? wptr_q + ptr_one : wptr_q;
    rptr_d    = rd_accept ? rptr_q + ptr_one : rptr_q;
    rdata_d   = rd_accept ? mem_q[rptr_q[ptr_width-1:0]] : rdata_q;
    werr_d    = wen && full;
    rerr_d    = ren && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
      werr_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
      werr_q  <= werr_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is deliberately left uncleared by reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wptr_q[ptr_width-1:0]] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign werr  = werr_q;
  assign rerr  = rerr_q;

`ifdef SYNC_FIFO_LEVEL_EN
  assign level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed fill/drain/wrap/simultaneous/reset
// sequences, a queue-based read-data scoreboard and per-cycle flag checks.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 16;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wen = 1'b0;
  logic         ren = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         full, empty, werr, rerr;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [P:0]   level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];    // read data the monitor should see, in order
  logic [W-1:0] model_q[$];  // bench model of FIFO contents
  logic [W-1:0] exp_rdata;

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  sync_fifo #(.width(W), .depth(D), .ptr_width(P)) dut (
`ifdef SYNC_FIFO_LEVEL_EN
    .level(level),
`endif
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .wdata(wdata),
    .full(full),
    .werr(werr),
    .ren(ren),
    .rdata(rdata),
    .empty(empty),
    .rerr(rerr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: an accepted read presents rdata one cycle later
  always @(posedge clk) begin
    if (!rst && ren && !empty) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected no read", rdata);
      end else begin
        check("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_flags(input bit exp_werr, input bit exp_rerr);
    int cnt;
    cnt = model_q.size();
    check("empty", 32'(empty), 32'(cnt == 0));
    check("full",  32'(full),  32'(cnt == D));
    check("werr",  32'(werr),  32'(exp_werr));
    check("rerr",  32'(rerr),  32'(exp_rerr));
    check("rdata_hold", 32'(rdata), 32'(exp_rdata));
`ifdef SYNC_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(cnt));
`endif
  endtask

  // Driver: one clock of stimulus, model update from pre-edge occupancy
  task automatic step(input bit w, input logic [W-1:0] d, input bit r);
    int  cnt;
    bit  e_werr, e_rerr;
    @(negedge clk);
    wen   = w;
    wdata = d;
    ren   = r;
    cnt    = model_q.size();
    e_werr = w && (cnt == D);
    e_rerr = r && (cnt == 0);
    if (r && cnt > 0) begin
      exp_rdata = model_q.pop_front();
      exp_q.push_back(exp_rdata);
    end
    if (w && cnt < D) model_q.push_back(d);
    @(posedge clk);
    #1;
    check_flags(e_werr, e_rerr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    wen   = 1'b1;
    ren   = 1'b1;
    wdata = 8'h55;
    model_q.delete();
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_flags(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    exp_rdata = '0;
    do_reset();

    // Fill with known values, then overflow
    for (int i = 0; i < D; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Drain in order, then underflow; rdata holds the last value
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Partial fill across the wrap point: 3 in, 2 out, one left
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous at one entry: occupancy stays 1
    step(1'b1, 8'hB4, 1'b1);
    step(1'b1, 8'hB5, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous when full: write rejected, one word read
    for (int i = 0; i < D; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 8'hCF, 1'b1);
    for (int i = 0; i < D - 1; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous when empty: read rejected, write stored
    step(1'b1, 8'hD7, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset mid-operation discards contents
    for (int i = 0; i < 5; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Mixed traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised first-in first-out buffer with full/empty status and write/read error flags.
- Sits between a producer and a consumer in the same clock domain.
- Stores up to `depth` words of `width` bits.
- Reports and drops illegal operations: write when full, read when empty.

Parameters:
- width, 8, data word width in bits.
- depth, 16, number of storage entries; must equal 2**ptr_width.
- ptr_width, 4, address width for storage; internal pointers are ptr_width+1 bits (extra wrap bit).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- wen  input  1  write request, sampled at rising edge of clk.
- wdata  input  width  write data, captured when a write is accepted.
- full  output  1  FIFO holds depth entries.
- werr  output  1  write-error pulse.
- ren  input  1  read request, sampled at rising edge of clk.
- rdata  output  width  read data register.
- empty  output  1  FIFO holds zero entries.
- rerr  output  1  read-error pulse.

Behaviour:
- Reset (rst=1 at rising edge):
  - write pointer and read pointer cleared to 0.
  - rdata=0, werr=0, rerr=0, hence empty=1 and full=0.
  - storage array is not cleared.
  - rst overrides wen/ren in the same cycle; reset mid-operation discards all contents.
- Flags:
  - full and empty are combinational from the registered pointers.
  - empty when wptr==rptr (all ptr_width+1 bits).
  - full when the MSBs differ and the lower ptr_width bits are equal.
- Write: wen=1 and full=0 at an edge -> mem[wptr[ptr_width-1:0]] <= wdata; wptr increments by 1 (mod 2**(ptr_width+1)).
- Write error: wen=1 and full=1 -> data dropped, pointer unchanged, werr=1 for the following cycle.
- Read: ren=1 and empty=0 at an edge -> rdata <= mem[rptr[ptr_width-1:0]]; rptr increments.
  - Latency: data valid one cycle after the accepting edge; rdata holds its value otherwise.
- Read error: ren=1 and empty=1 -> rdata unchanged, pointer unchanged, rerr=1 for the following cycle.
- werr/rerr are registered one-cycle pulses; they deassert on any edge where the corresponding error condition is absent.
- Simultaneous wen and ren:
  - Each is judged against the pre-edge flags.
  - When full: read proceeds, write is rejected with werr.
  - When empty: write proceeds, read is rejected with rerr.
  - Otherwise both proceed and occupancy is unchanged.
- Wrap-around: pointer low bits wrap from depth-1 to 0; the wrap bit toggles, which disambiguates full from empty.
- Ordering: data is returned strictly in write order.

Optional Feature:
- Macro SYNC_FIFO_LEVEL_EN.
- Defined: adds output port level [ptr_width:0], equal to wptr-rptr (current occupancy 0..depth). It is combinational from the pointers and reads 0 after reset.
- Undefined: port absent, no occupancy logic; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> empty=1, full=0, werr=0, rerr=0, rdata=0; wen/ren during reset are ignored.
- Fill: 16 single-cycle writes of known values -> empty=0 after the first; full=1 exactly after the 16th. A 17th write -> werr=1 for one cycle, contents unchanged.
- Drain: 16 reads -> rdata matches the write order, each one cycle after its accepting edge; empty=1 after the 16th. A further read -> rerr=1 for one cycle, rdata holds the last value.
- Partial/wrap: write 3 values, read 2 -> first two values returned in order; empty=0 with one entry left (level=1 if SYNC_FIFO_LEVEL_EN).
- Simultaneous:
  - wen+ren at one entry -> occupancy stays 1, correct data returned.
  - wen+ren when full -> werr=1 and one word read.
  - wen+ren when empty -> rerr=1 and the write is stored.
- Reset mid-operation: after 5 writes, assert rst -> empty=1, full=0, and a subsequent read gives rerr=1.
